// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: the writeback stage always wins the port, and side-unit results
// wait in a small in-order FIFO until a free slot. A starvation FSM requests bubbles when the FIFO head waits too long.
module regfile_wb_arbiter #(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     RegWriteW,
  input  logic [4:0]               RdW,
  input  logic [31:0]              ResultW,
  input  logic                     b_valid,
  input  logic [4:0]               b_rd,
  input  logic [31:0]              b_data,
  output logic                     b_ready,
  output logic                     stall_req,
  output logic                     RegWrite,
  output logic [4:0]               Rd,
  output logic [31:0]              Result,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PEND,
    ST_STALL
  } state_t;

  logic [4:0]    r_mem_rd   [DEPTH];
  logic [31:0]   r_mem_data [DEPTH];
  logic [AW:0]   r_wptr;
  logic [AW:0]   r_rptr;
  logic          r_reg_write;
  logic [4:0]    r_rd;
  logic [31:0]   r_result;
  logic          r_stall_req;
  state_t        r_state;
  logic [CW-1:0] r_cnt;

  logic          w_a_live;
  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic [AW:0]   w_count;
  logic [AW:0]   w_count_next;
  logic [4:0]    w_head_rd;
  logic [31:0]   w_head_data;
  state_t        w_state_next;
  logic [CW-1:0] w_cnt_next;

  assign w_a_live     = RegWriteW && (RdW != 5'd0);
  assign w_empty      = (r_wptr == r_rptr);
  assign w_full       = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_pop        = !w_a_live && !w_empty;
  // A zero destination still completes the handshake but is never stored.
  assign w_push       = b_valid && !w_full && (b_rd != 5'd0);
  assign w_count      = r_wptr - r_rptr;
  assign w_count_next = w_count + (AW + 1)'(w_push) - (AW + 1)'(w_pop);
  assign w_head_rd    = r_mem_rd[r_rptr[AW-1:0]];
  assign w_head_data  = r_mem_data[r_rptr[AW-1:0]];

  assign b_ready    = !w_full;
  assign fifo_count = w_count;
  assign stall_req  = r_stall_req;
  assign RegWrite   = r_reg_write;
  assign Rd         = r_rd;
  assign Result     = r_result;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_rd[r_wptr[AW-1:0]]   <= b_rd;
      r_mem_data[r_wptr[AW-1:0]] <= b_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  // Rd/Result keep their last value on idle slots; only the enable drops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_reg_write <= 1'b0;
      r_rd        <= 5'd0;
      r_result    <= 32'd0;
    end else if (w_a_live) begin
      r_reg_write <= 1'b1;
      r_rd        <= RdW;
      r_result    <= ResultW;
    end else if (w_pop) begin
      r_reg_write <= 1'b1;
      r_rd        <= w_head_rd;
      r_result    <= w_head_data;
    end else begin
      r_reg_write <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_stall_req <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_stall_req <= (w_state_next == ST_STALL);
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        w_cnt_next = '0;
        if (w_push) w_state_next = ST_PEND;
      end
      ST_PEND: begin
        if (w_pop) begin
          w_cnt_next = '0;
          if (w_count_next == '0) w_state_next = ST_IDLE;
        end else if ((r_cnt + CW'(1)) >= CW'(STARVE_MAX)) begin
          w_cnt_next   = CW'(STARVE_MAX);
          w_state_next = ST_STALL;
        end else begin
          w_cnt_next = r_cnt + CW'(1);
        end
      end
      ST_STALL: begin
        if (w_pop) begin
          w_cnt_next   = '0;
          w_state_next = (w_count_next == '0) ? ST_IDLE : ST_PEND;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed, table-driven bench for regfile_wb_arbiter (DEPTH=4, STARVE_MAX=8) with hand-computed expectations.
module tb_regfile_wb_arbiter;

  logic        clk;
  logic        rst;
  logic        RegWriteW;
  logic [4:0]  RdW;
  logic [31:0] ResultW;
  logic        b_valid;
  logic [4:0]  b_rd;
  logic [31:0] b_data;
  logic        b_ready;
  logic        stall_req;
  logic        RegWrite;
  logic [4:0]  Rd;
  logic [31:0] Result;
  logic [2:0]  fifo_count;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        we;
    logic [4:0]  rdw;
    logic [31:0] resw;
    logic        bv;
    logic [4:0]  brd;
    logic [31:0] bdata;
    logic        e_we;
    logic [4:0]  e_rd;
    logic [31:0] e_res;
    logic        e_rdy;
    logic [2:0]  e_cnt;
    logic        e_st;
  } vec_t;

  localparam int NV = 36;
  vec_t vecs [NV];

  regfile_wb_arbiter #(.DEPTH(4), .STARVE_MAX(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .RegWriteW  (RegWriteW),
    .RdW        (RdW),
    .ResultW    (ResultW),
    .b_valid    (b_valid),
    .b_rd       (b_rd),
    .b_data     (b_data),
    .b_ready    (b_ready),
    .stall_req  (stall_req),
    .RegWrite   (RegWrite),
    .Rd         (Rd),
    .Result     (Result),
    .fifo_count (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(logic we, logic [4:0] rdw, logic [31:0] resw,
                              logic bv, logic [4:0] brd, logic [31:0] bdata,
                              logic e_we, logic [4:0] e_rd, logic [31:0] e_res,
                              logic e_rdy, logic [2:0] e_cnt, logic e_st);
    vec_t v;
    v.we = we; v.rdw = rdw; v.resw = resw; v.bv = bv; v.brd = brd; v.bdata = bdata;
    v.e_we = e_we; v.e_rd = e_rd; v.e_res = e_res; v.e_rdy = e_rdy; v.e_cnt = e_cnt; v.e_st = e_st;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(string tag, logic e_we, logic [4:0] e_rd, logic [31:0] e_res,
                         logic e_rdy, logic [2:0] e_cnt, logic e_st);
    chk({tag, ".RegWrite"},   32'(RegWrite),   32'(e_we));
    chk({tag, ".Rd"},         32'(Rd),         32'(e_rd));
    chk({tag, ".Result"},     Result,          e_res);
    chk({tag, ".b_ready"},    32'(b_ready),    32'(e_rdy));
    chk({tag, ".fifo_count"}, 32'(fifo_count), 32'(e_cnt));
    chk({tag, ".stall_req"},  32'(stall_req),  32'(e_st));
  endtask

  task automatic drive(logic we, logic [4:0] rdw, logic [31:0] resw,
                       logic bv, logic [4:0] brd, logic [31:0] bdata);
    RegWriteW = we; RdW = rdw; ResultW = resw;
    b_valid = bv; b_rd = brd; b_data = bdata;
  endtask

  initial begin
    // writeback priority, idle drain, full FIFO
    vecs[0]  = mk(1, 5, 32'hAAAA5555, 0, 0,  0,        1, 5,  32'hAAAA5555, 1, 0, 0);
    vecs[1]  = mk(0, 0, 0,            1, 3,  32'h11,   0, 5,  32'hAAAA5555, 1, 1, 0);
    vecs[2]  = mk(0, 0, 0,            0, 0,  0,        1, 3,  32'h11,       1, 0, 0);
    vecs[3]  = mk(0, 0, 0,            0, 0,  0,        0, 3,  32'h11,       1, 0, 0);
    vecs[4]  = mk(1, 1, 32'h100,      1, 10, 32'hA0,   1, 1,  32'h100,      1, 1, 0);
    vecs[5]  = mk(1, 2, 32'h200,      1, 11, 32'hA1,   1, 2,  32'h200,      1, 2, 0);
    vecs[6]  = mk(1, 3, 32'h300,      1, 12, 32'hA2,   1, 3,  32'h300,      1, 3, 0);
    vecs[7]  = mk(1, 4, 32'h400,      1, 13, 32'hA3,   1, 4,  32'h400,      0, 4, 0);
    vecs[8]  = mk(1, 5, 32'h500,      1, 14, 32'hA4,   1, 5,  32'h500,      0, 4, 0);
    vecs[9]  = mk(0, 0, 0,            0, 0,  0,        1, 10, 32'hA0,       1, 3, 0);
    vecs[10] = mk(0, 0, 0,            0, 0,  0,        1, 11, 32'hA1,       1, 2, 0);
    vecs[11] = mk(0, 0, 0,            0, 0,  0,        1, 12, 32'hA2,       1, 1, 0);
    vecs[12] = mk(0, 0, 0,            0, 0,  0,        1, 13, 32'hA3,       1, 0, 0);
    vecs[13] = mk(0, 0, 0,            0, 0,  0,        0, 13, 32'hA3,       1, 0, 0);
    // starvation: one queued entry behind a busy writeback stage
    vecs[14] = mk(1, 7, 32'h700,      1, 20, 32'hB0,   1, 7,  32'h700,      1, 1, 0);
    for (int i = 15; i <= 21; i++)
      vecs[i] = mk(1, 7, 32'h700,     0, 0,  0,        1, 7,  32'h700,      1, 1, 0);
    vecs[22] = mk(1, 7, 32'h700,      0, 0,  0,        1, 7,  32'h700,      1, 1, 1);
    vecs[23] = mk(1, 7, 32'h700,      0, 0,  0,        1, 7,  32'h700,      1, 1, 1);
    vecs[24] = mk(0, 0, 0,            0, 0,  0,        1, 20, 32'hB0,       1, 0, 0);
    vecs[25] = mk(0, 0, 0,            0, 0,  0,        0, 20, 32'hB0,       1, 0, 0);
    // corners: rd=0 push dropped, RdW=0 treated idle, push+pop together, full with pop
    vecs[26] = mk(0, 0, 0,            1, 0,  32'hDEAD, 0, 20, 32'hB0,       1, 0, 0);
    vecs[27] = mk(0, 0, 0,            1, 9,  32'h99,   0, 20, 32'hB0,       1, 1, 0);
    vecs[28] = mk(1, 0, 32'hFFFF,     1, 8,  32'h88,   1, 9,  32'h99,       1, 1, 0);
    vecs[29] = mk(1, 0, 32'hFFFF,     1, 6,  32'h66,   1, 8,  32'h88,       1, 1, 0);
    vecs[30] = mk(0, 0, 0,            0, 0,  0,        1, 6,  32'h66,       1, 0, 0);
    vecs[31] = mk(1, 1, 32'h1,        1, 1,  32'hC1,   1, 1,  32'h1,        1, 1, 0);
    vecs[32] = mk(1, 1, 32'h2,        1, 2,  32'hC2,   1, 1,  32'h2,        1, 2, 0);
    vecs[33] = mk(1, 1, 32'h3,        1, 3,  32'hC3,   1, 1,  32'h3,        1, 3, 0);
    vecs[34] = mk(1, 1, 32'h4,        1, 4,  32'hC4,   1, 1,  32'h4,        0, 4, 0);
    vecs[35] = mk(0, 0, 0,            1, 5,  32'hC5,   1, 1,  32'hC1,       1, 3, 0);

    // reset held with inputs toggling
    rst = 1'b0;
    drive(1, 5'd7, 32'h1234, 1, 5'd4, 32'h55);
    #2;
    chk_all("rst_async", 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      drive(1'(i), 5'(i + 3), 32'hF0F0_0000 + 32'(i), 1'(~i), 5'(i + 1), 32'(i * 7));
      chk_all($sformatf("rst_hold%0d", i), 0, 0, 0, 1, 0, 0);
      $display("reset cycle %0d RegWrite=%0b fifo_count=%0d", i, RegWrite, fifo_count);
    end
    drive(0, 0, 0, 0, 0, 0);
    rst = 1'b1;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].we, vecs[i].rdw, vecs[i].resw, vecs[i].bv, vecs[i].brd, vecs[i].bdata);
      @(posedge clk); #1;
      chk_all($sformatf("vec%0d", i), vecs[i].e_we, vecs[i].e_rd, vecs[i].e_res,
              vecs[i].e_rdy, vecs[i].e_cnt, vecs[i].e_st);
      $display("vec %0d: RegWrite=%0b Rd=%0d Result=%h b_ready=%0b fifo_count=%0d stall_req=%0b",
               i, RegWrite, Rd, Result, b_ready, fifo_count, stall_req);
    end

    // reset pulse with three entries still queued
    drive(0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    #2;
    chk_all("midrst", 0, 0, 0, 1, 0, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk_all($sformatf("post_rst%0d", i), 0, 0, 0, 1, 0, 0);
      $display("post-reset cycle %0d RegWrite=%0b fifo_count=%0d", i, RegWrite, fifo_count);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
